uart_rx_deframer: RTL and testbench

Parametrised, clocked frame splitter for the UART receive path, sitting between the receive SIPO shifter and the host/bus interface. It takes a complete serial frame captured LSB-first and separates the start, data, parity and stop fields. It checks parity and framing, then queues the data byte with per-entry error tags in a small output FIFO drained by a valid/ready handshake. It adds runtime parity mode, width and stop-bit generality, error detection, buffering and overrun reporting.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_fifo.sv | 74 +++++++
 rtl/uart_rx_deframer.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive deframer: parity-mode
// encoding, stop-field offsets and the value shown by an empty output queue.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } par_mode_e;

    // Widest supported data field is 9 bits; users slice to DATA_W.
    localparam logic [8:0] IDLE_DATA = 9'h1FF;

    // The reserved encoding 2'b11 behaves exactly like "no parity".
    function automatic par_mode_e decode_mode(input logic [1:0] raw);
        par_mode_e m;
        case (raw)
            2'b01:   m = PAR_EVEN;
            2'b10:   m = PAR_ODD;
            default: m = PAR_NONE;
        endcase
        return m;
    endfunction

    // Index of the first stop bit: after start, data and (optionally) parity.
    function automatic int stop_base(input int data_w, input logic parity_on);
        int base;
        if (parity_on) begin
            base = data_w + 2;
        end else begin
            base = data_w + 1;
        end
        return base;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for deframed UART entries. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module uart_rx_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      fill_o
);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;
    logic [AW:0]      fill_s;

    assign fill_s  = wr_q - rd_q;
    assign full_o  = (fill_s == (AW+1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign fill_o  = fill_s;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign wr_en_s = push_i & (~full_o | pop_i);
    assign rd_en_s = pop_i & ~empty_o;

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (wr_en_s) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (rd_en_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_q <= {(AW+1){1'b0}};
            rd_q <= {(AW+1){1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: captures a full frame, checks parity and framing,
// and queues tagged data bytes. Break detection is enabled by UART_RX_BREAK_DETECT_EN.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int STOP_BITS = 1,
    parameter  int DEPTH     = 2,
    localparam int FRAME_W   = 2 + DATA_W + STOP_BITS,
    localparam int FILL_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic [1:0]         parity_mode,
    input  logic               err_clr,
    output logic [DATA_W-1:0]  data_out,
    output logic               parity_err,
    output logic               frame_err,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               overrun_err,
    output logic               break_det,
    output logic [FILL_W-1:0]  fill
);

    localparam int ENTRY_W     = DATA_W + 2;
    localparam int STOP_PAR    = stop_base(DATA_W, 1'b1);
    localparam int STOP_NO_PAR = stop_base(DATA_W, 1'b0);

    logic               cap_vld_q, cap_vld_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    par_mode_e          mode_q, mode_d;

    logic [DATA_W-1:0]    data_s;
    logic                 par_bit_s;
    logic [STOP_BITS-1:0] stops_s;
    logic                 perr_s;
    logic                 ferr_s;
    logic                 is_break_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 drop_s;

    logic               overrun_q, overrun_d;
    logic               break_q, break_d;

    logic [ENTRY_W-1:0] head_s;
    logic               full_s;
    logic               empty_s;

    // Capture stage next-state: a strobe always loads, otherwise hold the last frame.
    always_comb begin
        cap_vld_d = frame_valid;
        frame_d   = frame_q;
        mode_d    = mode_q;
        if (frame_valid) begin
            frame_d = frame_in;
            mode_d  = decode_mode(parity_mode);
        end else begin
            frame_d = frame_q;
            mode_d  = mode_q;
        end
    end

    // Capture stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_vld_q <= 1'b0;
            frame_q   <= {FRAME_W{1'b0}};
            mode_q    <= PAR_NONE;
        end else begin
            cap_vld_q <= cap_vld_d;
            frame_q   <= frame_d;
            mode_q    <= mode_d;
        end
    end

    assign data_s    = frame_q[DATA_W:1];
    assign par_bit_s = frame_q[DATA_W+1];

    // Field checks; without parity the stop field slides down by one bit.
    always_comb begin
        perr_s  = 1'b0;
        stops_s = frame_q[STOP_NO_PAR +: STOP_BITS];
        case (mode_q)
            PAR_EVEN: begin
                perr_s  = ((^data_s) ^ par_bit_s) != 1'b0;
                stops_s = frame_q[STOP_PAR +: STOP_BITS];
            end
            PAR_ODD: begin
                perr_s  = ((^data_s) ^ par_bit_s) != 1'b1;
                stops_s = frame_q[STOP_PAR +: STOP_BITS];
            end
            default: begin
                perr_s  = 1'b0;
                stops_s = frame_q[STOP_NO_PAR +: STOP_BITS];
            end
        endcase
        ferr_s = frame_q[0] | (stops_s != {STOP_BITS{1'b1}});
    end

`ifdef UART_RX_BREAK_DETECT_EN
    assign is_break_s = (frame_q == {FRAME_W{1'b0}});
`else
    assign is_break_s = 1'b0;
`endif

    assign pop_s  = ~empty_s & data_ready;
    assign push_s = cap_vld_q & ~is_break_s;
    assign drop_s = push_s & full_s & ~pop_s;

    // Sticky overrun and break pulse next-state; a fresh drop beats a clear.
    always_comb begin
        overrun_d = overrun_q;
        break_d   = cap_vld_q & is_break_s;
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            break_q   <= break_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .wdata_i   ({perr_s, ferr_s, data_s}),
        .rdata_o   (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .fill_o    (fill)
    );

    // Empty queue shows an idle all-ones byte with clean tags.
    always_comb begin
        data_out   = IDLE_DATA[DATA_W-1:0];
        parity_err = 1'b0;
        frame_err  = 1'b0;
        if (!empty_s) begin
            data_out   = head_s[DATA_W-1:0];
            frame_err  = head_s[DATA_W];
            parity_err = head_s[DATA_W+1];
        end else begin
            data_out   = IDLE_DATA[DATA_W-1:0];
            parity_err = 1'b0;
            frame_err  = 1'b0;
        end
    end

    assign data_valid  = ~empty_s;
    assign overrun_err = overrun_q;
    assign break_det   = break_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised bench for uart_rx_deframer (DATA_W=8, STOP_BITS=1, DEPTH=2)
// against a queue-based reference model of the frame rules.
module tb_uart_rx_deframer;

    localparam int DW    = 8;
    localparam int FW    = 11;
    localparam int DEPTH = 2;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frame_valid;
    logic [FW-1:0] frame_in;
    logic [1:0]    parity_mode;
    logic          err_clr;
    logic [DW-1:0] data_out;
    logic          parity_err;
    logic          frame_err;
    logic          data_valid;
    logic          data_ready;
    logic          overrun_err;
    logic          break_det;
    logic [1:0]    fill;

    int checks   = 0;
    int failures = 0;

    // Model state: queued entries {perr, ferr, data}, one captured frame in flight.
    logic [DW+1:0] mq[$];
    logic          m_pend;
    logic [FW-1:0] m_pframe;
    logic [1:0]    m_pmode;
    logic          m_ovr;
    logic          m_brk;

    uart_rx_deframer #(.DATA_W(DW), .STOP_BITS(1), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_valid (frame_valid),
        .frame_in    (frame_in),
        .parity_mode (parity_mode),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overrun_err (overrun_err),
        .break_det   (break_det),
        .fill        (fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Build a frame: start, data LSB-first, optional parity, one stop bit.
    function automatic logic [FW-1:0] mk(input logic [7:0] d, input logic [1:0] md,
                                         input logic bad_par, input logic stp, input logic st);
        logic p;
        p = (md == 2'b10) ? ~(^d) : (^d);
        p = p ^ bad_par;
        if (md == 2'b01 || md == 2'b10) begin
            return {stp, p, d, st};
        end else begin
            return {1'b0, stp, d, st};
        end
    endfunction

    function automatic logic [DW+1:0] expect_entry(input logic [FW-1:0] fr, input logic [1:0] md);
        logic [7:0] d;
        int         ones;
        logic       pe;
        logic       fe;
        logic       stp;
        d    = fr[8:1];
        ones = $countones(d) + int'(fr[9]);
        pe   = 1'b0;
        stp  = fr[9];
        if (md == 2'b01) begin
            pe = (ones % 2) != 0;
            stp = fr[10];
        end else if (md == 2'b10) begin
            pe = (ones % 2) == 0;
            stp = fr[10];
        end
        fe = (fr[0] != 1'b0) || (stp != 1'b1);
        return {pe, fe, d};
    endfunction

    task automatic model_edge();
        int   sz;
        logic popping;
        sz      = mq.size();
        popping = (sz > 0) && data_ready;
        m_brk   = 1'b0;
        if (m_pend && BRK_EN && (m_pframe == '0)) begin
            m_brk = 1'b1;
            if (err_clr) m_ovr = 1'b0;
        end else if (m_pend && sz == DEPTH && !popping) begin
            m_ovr = 1'b1;
        end else begin
            if (m_pend) mq.push_back(expect_entry(m_pframe, m_pmode));
            if (err_clr) m_ovr = 1'b0;
        end
        if (popping) void'(mq.pop_front());
        m_pend   = frame_valid;
        m_pframe = frame_in;
        m_pmode  = parity_mode;
    endtask

    task automatic compare_all(input string where);
        logic [DW+1:0] hd;
        hd = (mq.size() > 0) ? mq[0] : {2'b00, 8'hFF};
        chk({where, ".valid"},   32'(data_valid),  32'(mq.size() > 0));
        chk({where, ".fill"},    32'(fill),        32'(mq.size()));
        chk({where, ".data"},    32'(data_out),    32'(hd[7:0]));
        chk({where, ".ferr"},    32'(frame_err),   32'(hd[8]));
        chk({where, ".perr"},    32'(parity_err),  32'(hd[9]));
        chk({where, ".overrun"}, 32'(overrun_err), 32'(m_ovr));
        chk({where, ".break"},   32'(break_det),   32'(m_brk));
    endtask

    task automatic step(input string where, input logic fv, input logic [FW-1:0] fr,
                        input logic [1:0] md, input logic rdy, input logic clr);
        @(negedge clk);
        frame_valid = fv;
        frame_in    = fr;
        parity_mode = md;
        data_ready  = rdy;
        err_clr     = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(where);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 1'b0; m_pframe = '0; m_pmode = 2'b00; m_ovr = 1'b0; m_brk = 1'b0;
    endtask

    logic [FW-1:0] f55;

    initial begin
        reset_n = 1'b0; frame_valid = 1'b0; frame_in = '0; parity_mode = 2'b00;
        err_clr = 1'b0; data_ready = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 0x55 with even parity, then the same bits interpreted as odd, then framing errors.
        f55 = mk(8'h55, 2'b01, 1'b0, 1'b1, 1'b0);
        step("even55", 1'b1, f55, 2'b01, 1'b0, 1'b0);
        step("even55_lat", 1'b0, '0, 2'b00, 1'b0, 1'b0);
        step("even55_pop", 1'b0, '0, 2'b00, 1'b1, 1'b0);
        step("odd55", 1'b1, f55, 2'b10, 1'b1, 1'b0);
        step("stop0", 1'b1, mk(8'hA3, 2'b01, 1'b0, 1'b0, 1'b0), 2'b01, 1'b1, 1'b0);
        step("start1", 1'b1, mk(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1), 2'b00, 1'b1, 1'b0);
        step("drain", 1'b0, '0, 2'b00, 1'b1, 1'b0);
        step("drain", 1'b0, '0, 2'b00, 1'b1, 1'b0);

        // Three frames into a stalled two-entry queue: third dropped.
        for (int i = 0; i < 3; i++)
            step("ovr_fill", 1'b1, mk(8'(8'h10 + i), 2'b01, 1'b0, 1'b1, 1'b0), 2'b01, 1'b0, 1'b0);
        step("ovr_flag", 1'b0, '0, 2'b00, 1'b0, 1'b0);
        step("ovr_clr", 1'b0, '0, 2'b00, 1'b0, 1'b1);
        step("ovr_pop", 1'b0, '0, 2'b00, 1'b1, 1'b0);
        step("ovr_pop", 1'b0, '0, 2'b00, 1'b1, 1'b0);

        // Keep the queue full while pushing and popping each cycle.
        step("wrap_fill", 1'b1, mk(8'h80, 2'b10, 1'b0, 1'b1, 1'b0), 2'b10, 1'b0, 1'b0);
        step("wrap_fill", 1'b1, mk(8'h81, 2'b10, 1'b0, 1'b1, 1'b0), 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step("wrap", 1'b1, mk(8'(8'h90 + i), 2'b10, 1'b0, 1'b1, 1'b0), 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("wrap_drain", 1'b0, '0, 2'b00, 1'b1, 1'b0);

        // All-zero frame: break or plain data with a framing error.
        step("zero", 1'b1, '0, 2'b01, 1'b0, 1'b0);
        step("zero_a", 1'b0, '0, 2'b00, 1'b0, 1'b0);
        step("zero_b", 1'b0, '0, 2'b00, 1'b1, 1'b0);

        // Reset asserted between edges with entries queued and a frame in flight.
        step("pre_rst", 1'b1, mk(8'h11, 2'b00, 1'b0, 1'b1, 1'b0), 2'b00, 1'b0, 1'b0);
        step("pre_rst", 1'b1, mk(8'h22, 2'b00, 1'b0, 1'b1, 1'b0), 2'b00, 1'b0, 1'b0);
        step("pre_rst", 1'b1, mk(8'h33, 2'b00, 1'b0, 1'b1, 1'b0), 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        frame_valid = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        step("post_rst", 1'b0, '0, 2'b00, 1'b1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            logic [FW-1:0] fr;
            logic [1:0]    md;
            md = 2'($urandom_range(0, 3));
            fr = mk(8'($urandom), md, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 19) == 0) fr = '0;
            step("rand", ($urandom_range(0, 9) < 7), fr, md,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
